// File: rtl/wash_panel_ctrl.sv
// Front-panel initiator for the wash controller: button debounce, 1 s tick,
// program selection, run/power flags, mode-load strobe and end-of-cycle alarm.
module wash_panel_ctrl #(
  parameter int TICK_DIV  = 50000000,
  parameter int DB_CYCLES = 1000000,
  parameter int ALARM_S   = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_mode,
  input  logic       btn_start,
  input  logic       btn_power,
  input  logic [5:0] tt_in,
  output logic       ts,
  output logic       s,
  output logic       p,
  output logic       mod,
  output logic [2:0] mod1,
  output logic [5:0] Tt1,
  output logic       alarm
);

  localparam int DW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DBW = $clog2(DB_CYCLES + 1);
  localparam int AW  = $clog2(ALARM_S + 1);

  typedef enum logic [2:0] {
    S_OFF,
    S_IDLE,
    S_RUN,
    S_PAUSE,
    S_DONE
  } state_t;

  function automatic logic [5:0] f_time(input logic [2:0] m);
    case (m)
      3'd1:    f_time = 6'd12;
      3'd2:    f_time = 6'd27;
      3'd3:    f_time = 6'd15;
      3'd4:    f_time = 6'd21;
      3'd5:    f_time = 6'd6;
      default: f_time = 6'd33;
    endcase
  endfunction

  // bit 2 = power, bit 1 = start, bit 0 = mode
  logic [2:0]     w_btn;
  logic [2:0]     r_sy1;
  logic [2:0]     r_sy2;
  logic [2:0]     r_db;
  logic [2:0]     r_press;
  logic [DBW-1:0] r_dbc [3];

  assign w_btn = {btn_power, btn_start, btn_mode};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sy1   <= '0;
      r_sy2   <= '0;
      r_db    <= '0;
      r_press <= '0;
      for (int i = 0; i < 3; i++) r_dbc[i] <= '0;
    end else begin
      r_sy1 <= w_btn;
      r_sy2 <= r_sy1;
      for (int i = 0; i < 3; i++) begin
        r_press[i] <= 1'b0;
        if (r_sy2[i] == r_db[i]) begin
          r_dbc[i] <= '0;
        end else if (r_dbc[i] == DBW'(DB_CYCLES - 1)) begin
          r_db[i]    <= r_sy2[i];
          r_dbc[i]   <= '0;
          r_press[i] <= r_sy2[i];
        end else begin
          r_dbc[i] <= r_dbc[i] + 1'b1;
        end
      end
    end
  end

  logic [DW-1:0] r_div;
  logic          r_ts;
  logic          w_wrap;

  assign w_wrap = (r_div == DW'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div <= '0;
      r_ts  <= 1'b0;
    end else begin
      r_div <= w_wrap ? '0 : r_div + 1'b1;
      r_ts  <= w_wrap;
    end
  end

  state_t        r_state;
  state_t        w_nxt;
  logic          r_s;
  logic          r_p;
  logic          r_alarm;
  logic [AW-1:0] r_acnt;
  logic [2:0]    r_mod1;
  logic [5:0]    r_tt1;
  logic          r_pend;
  logic          r_mod;
  logic          w_s;
  logic          w_p;
  logic          w_alarm;
  logic [AW-1:0] w_acnt;
  logic [2:0]    w_mod1;
  logic          w_load;
  logic          w_pw;
  logic          w_st;
  logic          w_md;
  logic [2:0]    w_inc;

  assign w_pw  = r_press[2];
  assign w_st  = r_press[1] & ~w_pw;
  assign w_md  = r_press[0] & ~r_press[1] & ~w_pw;
  assign w_inc = (r_mod1 == 3'd5) ? 3'd0 : r_mod1 + 3'd1;

  always_comb begin
    w_nxt   = r_state;
    w_s     = r_s;
    w_p     = r_p;
    w_alarm = r_alarm;
    w_acnt  = r_acnt;
    w_mod1  = r_mod1;
    w_load  = 1'b0;
    if (r_state != S_OFF && w_pw) begin
      w_nxt   = S_OFF;
      w_p     = 1'b0;
      w_s     = 1'b0;
      w_alarm = 1'b0;
    end else begin
      unique case (r_state)
        S_OFF: begin
          if (w_pw) begin
            w_nxt  = S_IDLE;
            w_p    = 1'b1;
            w_mod1 = 3'd0;
            w_load = 1'b1;
          end
        end
        S_IDLE: begin
          if (w_st) begin
            w_nxt = S_RUN;
            w_s   = 1'b1;
          end else if (w_md) begin
            w_mod1 = w_inc;
            w_load = 1'b1;
          end
        end
        S_RUN: begin
          if (w_st) begin
            w_nxt = S_PAUSE;
            w_s   = 1'b0;
          end else if (r_ts && tt_in == 6'd0) begin
            w_nxt   = S_DONE;
            w_s     = 1'b0;
            w_alarm = 1'b1;
            w_acnt  = '0;
          end
        end
        S_PAUSE: begin
          if (w_st) begin
            w_nxt = S_RUN;
            w_s   = 1'b1;
          end else if (w_md) begin
            w_nxt  = S_IDLE;
            w_mod1 = w_inc;
            w_load = 1'b1;
          end
        end
        S_DONE: begin
          if (w_st || w_md) begin
            w_nxt   = S_IDLE;
            w_alarm = 1'b0;
            w_load  = 1'b1;
          end else if (r_ts && r_alarm) begin
            if (r_acnt == AW'(ALARM_S - 1)) w_alarm = 1'b0;
            else w_acnt = r_acnt + 1'b1;
          end
        end
        default: w_nxt = S_OFF;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_OFF;
      r_s     <= 1'b0;
      r_p     <= 1'b0;
      r_alarm <= 1'b0;
      r_acnt  <= '0;
      r_mod1  <= 3'd0;
      r_tt1   <= 6'd33;
    end else begin
      r_state <= w_nxt;
      r_s     <= w_s;
      r_p     <= w_p;
      r_alarm <= w_alarm;
      r_acnt  <= w_acnt;
      r_mod1  <= w_mod1;
      r_tt1   <= f_time(w_mod1);
    end
  end

  // strobe trails the load by one cycle, one more if it would collide with ts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend <= 1'b0;
      r_mod  <= 1'b0;
    end else if (w_load) begin
      r_pend <= 1'b1;
      r_mod  <= 1'b0;
    end else if (r_pend && !w_wrap) begin
      r_pend <= 1'b0;
      r_mod  <= 1'b1;
    end else begin
      r_mod  <= 1'b0;
    end
  end

  assign ts    = r_ts;
  assign s     = r_s;
  assign p     = r_p;
  assign mod   = r_mod;
  assign mod1  = r_mod1;
  assign Tt1   = r_tt1;
  assign alarm = r_alarm;

endmodule

// File: tb/tb_wash_panel_ctrl.sv
// Directed bench for wash_panel_ctrl: vector table of button actions plus
// hand sequences for end-of-cycle alarm, ts/mod collision and reset.
module tb_wash_panel_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       btn_mode = 1'b0;
  logic       btn_start = 1'b0;
  logic       btn_power = 1'b0;
  logic [5:0] tt_in = 6'd5;
  logic       ts, s, p, mod, alarm;
  logic [2:0] mod1;
  logic [5:0] Tt1;

  int checks = 0;
  int failures = 0;
  int mod_total = 0;
  int bad_ts = 0;
  int bad_w = 0;
  logic prev_mod = 1'b0;

  wash_panel_ctrl #(
    .TICK_DIV (10),
    .DB_CYCLES(4),
    .ALARM_S  (2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn_mode (btn_mode),
    .btn_start(btn_start),
    .btn_power(btn_power),
    .tt_in    (tt_in),
    .ts       (ts),
    .s        (s),
    .p        (p),
    .mod      (mod),
    .mod1     (mod1),
    .Tt1      (Tt1),
    .alarm    (alarm)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (mod === 1'b1) begin
      mod_total++;
      if (ts) bad_ts++;
      if (prev_mod) bad_w++;
    end
    prev_mod = mod;
  end

  typedef struct {
    logic [2:0] btn;
    int         hold;
    logic       p;
    logic       s;
    logic [2:0] mod1;
    logic [5:0] tt1;
    logic       alarm;
    int         nmod;
  } vec_t;

  vec_t vecs[19];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  function automatic int tt_of(input int m);
    case (m)
      1: return 12;
      2: return 27;
      3: return 15;
      4: return 21;
      5: return 6;
      default: return 33;
    endcase
  endfunction

  task automatic press(input logic [2:0] b, input int hold);
    @(negedge clk);
    {btn_power, btn_start, btn_mode} = b;
    repeat (hold) @(negedge clk);
    {btn_power, btn_start, btn_mode} = 3'b000;
    repeat (14) @(negedge clk);
  endtask

  task automatic apply_vec(input int i);
    int base;
    base = mod_total;
    press(vecs[i].btn, vecs[i].hold);
    chk($sformatf("v%0d_p", i), p, vecs[i].p);
    chk($sformatf("v%0d_s", i), s, vecs[i].s);
    chk($sformatf("v%0d_mod1", i), mod1, vecs[i].mod1);
    chk($sformatf("v%0d_Tt1", i), Tt1, vecs[i].tt1);
    chk($sformatf("v%0d_alarm", i), alarm, vecs[i].alarm);
    chk($sformatf("v%0d_nmod", i), mod_total - base, vecs[i].nmod);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ts"}, ts, 0);
    chk({tag, "_s"}, s, 0);
    chk({tag, "_p"}, p, 0);
    chk({tag, "_mod"}, mod, 0);
    chk({tag, "_alarm"}, alarm, 0);
    chk({tag, "_mod1"}, mod1, 0);
    chk({tag, "_Tt1"}, Tt1, 33);
  endtask

  logic tsa[40];

  initial begin
    int  em, ndef, c, m, nts, base;
    bit  got;
    logic pm, pts;

    //          btn    hold p  s  mod1 tt1 al nmod
    vecs[0]  = '{3'b100, 10, 1, 0, 0, 33, 0, 1};
    vecs[1]  = '{3'b001, 10, 1, 0, 1, 12, 0, 1};
    vecs[2]  = '{3'b001, 10, 1, 0, 2, 27, 0, 1};
    vecs[3]  = '{3'b001, 10, 1, 0, 3, 15, 0, 1};
    vecs[4]  = '{3'b001, 10, 1, 0, 4, 21, 0, 1};
    vecs[5]  = '{3'b001, 10, 1, 0, 5, 6,  0, 1};
    vecs[6]  = '{3'b001, 10, 1, 0, 0, 33, 0, 1};
    vecs[7]  = '{3'b001, 2,  1, 0, 0, 33, 0, 0};
    vecs[8]  = '{3'b010, 10, 1, 1, 0, 33, 0, 0};
    vecs[9]  = '{3'b001, 10, 1, 1, 0, 33, 0, 0};
    vecs[10] = '{3'b010, 10, 1, 0, 0, 33, 0, 0};
    vecs[11] = '{3'b010, 10, 1, 1, 0, 33, 0, 0};
    vecs[12] = '{3'b010, 10, 1, 0, 0, 33, 0, 0};
    vecs[13] = '{3'b001, 10, 1, 0, 1, 12, 0, 1};
    vecs[14] = '{3'b010, 10, 1, 1, 1, 12, 0, 0};
    vecs[15] = '{3'b110, 10, 0, 0, 1, 12, 0, 0};
    vecs[16] = '{3'b100, 10, 1, 0, 0, 33, 0, 1};
    vecs[17] = '{3'b010, 10, 1, 1, 0, 33, 0, 0};
    vecs[18] = '{3'b001, 10, 1, 0, 0, 33, 0, 1};

    #2 rst_n = 1'b0;
    #1 chk_reset("rst0");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 18; i++) apply_vec(i);

    // RUN countdown: the wash controller decrements after each ts
    tt_in = 6'd3;
    got = 0;
    nts = 0;
    pts = 0;
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge clk);
      if (pts && tt_in > 0) tt_in = tt_in - 6'd1;
      pts = ts;
      if (ts) nts++;
      if (alarm) got = 1;
    end
    chk("done_reached", got, 1);
    chk("done_ts_count", nts, 4);
    chk("done_s", s, 0);
    chk("done_alarm", alarm, 1);
    for (int t = 0; t < 2; t++) begin
      got = 0;
      for (int k = 0; k < 20 && !got; k++) begin
        @(negedge clk);
        if (ts) got = 1;
      end
      @(negedge clk);
      chk($sformatf("alarm_ts%0d_seen", t), got, 1);
      chk($sformatf("alarm_after_ts%0d", t), alarm, (t == 0) ? 1 : 0);
    end
    chk("done_p", p, 1);
    apply_vec(18);

    // sweep the mode press across every ts phase
    tt_in = 6'd5;
    em = 0;
    ndef = 0;
    for (int off = 0; off < 10; off++) begin
      got = 0;
      for (int k = 0; k < 20 && !got; k++) begin
        @(negedge clk);
        if (ts) got = 1;
      end
      chk($sformatf("sw%0d_ts", off), got, 1);
      repeat (off) @(negedge clk);
      c = -1;
      m = -1;
      pm = mod1[0];
      for (int k = 0; k < 30; k++) begin
        @(negedge clk);
        tsa[k] = ts;
        if (c < 0 && mod1[0] !== pm) c = k;
        if (m < 0 && mod) m = k;
        pm = mod1[0];
        if (k == 0) btn_mode = 1'b1;
        if (k == 10) btn_mode = 1'b0;
      end
      em = (em == 5) ? 0 : em + 1;
      chk($sformatf("sw%0d_mod1", off), mod1, em);
      chk($sformatf("sw%0d_Tt1", off), Tt1, tt_of(em));
      chk($sformatf("sw%0d_load", off), (c >= 0 && c < 28), 1);
      if (c >= 0 && c < 28) begin
        if (tsa[c+1]) ndef++;
        chk($sformatf("sw%0d_strobe_cyc", off), m, c + 1 + (tsa[c+1] ? 1 : 0));
      end
    end
    chk("sweep_deferrals", ndef, 1);

    // reset in RUN
    press(3'b010, 10);
    chk("pre_rst_s", s, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1 chk_reset("rst_run");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // reset between load and strobe
    @(negedge clk);
    btn_power = 1'b1;
    got = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (p) got = 1;
    end
    chk("pwr_load_seen", got, 1);
    base = mod_total;
    rst_n = 1'b0;
    btn_power = 1'b0;
    #1 chk_reset("rst_load");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    chk("rst_load_nmod", mod_total - base, 0);
    chk("rst_load_p", p, 0);

    chk("mod_never_with_ts", bad_ts, 0);
    chk("mod_one_clk", bad_w, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
